// File: rtl/mulu_seq_ctrl_pkg.sv
// Shared definitions for the sequential wide multiplier controller:
// default digit geometry, FSM state encoding and small elaboration helpers.
package mulu_seq_ctrl_pkg;

   // Default core operand width (matches the mulu_x3y3 X/Y width) and digits per operand
   localparam int DEF_DIG_WIDTH = 2;
   localparam int DEF_NDIG      = 4;

   // Controller states, 2-bit encoding
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Width of the digit counters; never zero so a single-digit build still elaborates
   function automatic int cnt_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

   // Bit position at which the partial product of digit pair (i, j) lands
   function automatic int pp_shift(input int i, input int j, input int dig_width);
      return dig_width * (i + j);
   endfunction

endpackage

// File: rtl/mulu_x3y3.sv
// Narrow combinational unsigned multiplier core: X_WIDTH x Y_WIDTH -> P_WIDTH.
// The controller time-multiplexes this single instance over all digit pairs.
module mulu_x3y3 #(
   parameter int X_WIDTH = 2,
   parameter int Y_WIDTH = 2,
   parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
   input  logic [X_WIDTH-1:0] x,
   input  logic [Y_WIDTH-1:0] y,
   output logic [P_WIDTH-1:0] p
);

   // Full-width unsigned product; both factors widened first so no bits are lost
   always_comb begin
      p = P_WIDTH'(x) * P_WIDTH'(y);
   end

endmodule

// File: rtl/mulu_seq_ctrl.sv
// Sequencing controller for a wide multiply built from one narrow mulu_x3y3 core.
// Operands are taken as magnitudes, every digit pair is multiplied on its own cycle
// and accumulated at its weight, then a sign fix-up produces the final product.
module mulu_seq_ctrl
   import mulu_seq_ctrl_pkg::*;
#(
   parameter  int DIG_WIDTH = DEF_DIG_WIDTH,
   parameter  int NDIG      = DEF_NDIG,
   localparam int OP_W      = DIG_WIDTH * NDIG,
   localparam int PROD_W    = 2 * OP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_a,
   input  logic [OP_W-1:0]   req_b,
   input  logic              req_signed,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [PROD_W-1:0] rsp_p,
   output logic              rsp_sign
);

   localparam int                CNT_W    = cnt_width(NDIG);
   localparam int                CORE_W   = 2 * DIG_WIDTH;
   localparam logic [CNT_W-1:0]  LAST_DIG = CNT_W'(NDIG - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   // Two's complement magnitude; the most negative value maps onto its unsigned twin
   function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] x,
                                                 input logic            is_signed);
      return (is_signed && x[OP_W-1]) ? -x : x;
   endfunction

   state_t              state_reg;
   state_t              state_next;

   logic [OP_W-1:0]     a_mag_reg;
   logic [OP_W-1:0]     b_mag_reg;
   logic                neg_reg;
   logic [PROD_W-1:0]   acc_reg;
   logic [CNT_W-1:0]    i_reg;
   logic [CNT_W-1:0]    j_reg;
   logic [PROD_W-1:0]   rsp_p_reg;
   logic                rsp_sign_reg;

   logic [DIG_WIDTH-1:0] core_x;
   logic [DIG_WIDTH-1:0] core_y;
   logic [CORE_W-1:0]    core_p;

   logic                accept;
   logic                last_pp;
   logic [PROD_W-1:0]   pp_shifted;

   // A request is taken only while idle; anything offered in other states is ignored
   assign accept  = (state_reg == S_IDLE) && req_valid;
   // The final digit pair is (NDIG-1, NDIG-1) since j runs fastest
   assign last_pp = (i_reg == LAST_DIG) && (j_reg == LAST_DIG);

   // Current partial product moved to its digit-pair weight within the accumulator
   assign pp_shifted = PROD_W'(core_p) << pp_shift(int'(i_reg), int'(j_reg), DIG_WIDTH);

   // The single shared narrow multiplier
   mulu_x3y3 #(
      .X_WIDTH (DIG_WIDTH),
      .Y_WIDTH (DIG_WIDTH),
      .P_WIDTH (CORE_W)
   ) u_core (
      .x (core_x),
      .y (core_y),
      .p (core_p)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic: IDLE -> MUL -> FIX -> DONE -> IDLE
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         S_IDLE: begin
            if (req_valid) begin
               state_next = S_MUL;
            end
         end
         S_MUL: begin
            if (last_pp) begin
               state_next = S_FIX;
            end
         end
         S_FIX: begin
            state_next = S_DONE;
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // FSM outputs: handshakes and the digit selects feeding the core
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      core_x    = '0;
      core_y    = '0;
      unique case (state_reg)
         S_IDLE: begin
            // Held low while reset is asserted so nothing is offered during reset
            req_ready = !reset;
         end
         S_MUL: begin
            core_x = a_mag_reg[int'(i_reg)*DIG_WIDTH +: DIG_WIDTH];
            core_y = b_mag_reg[int'(j_reg)*DIG_WIDTH +: DIG_WIDTH];
         end
         S_FIX: begin
         end
         S_DONE: begin
            rsp_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Operand capture on accept: magnitudes plus the sign of the eventual product
   always_ff @(posedge clk) begin
      if (reset) begin
         a_mag_reg <= '0;
         b_mag_reg <= '0;
         neg_reg   <= 1'b0;
      end else if (accept) begin
         a_mag_reg <= magnitude(req_a, req_signed);
         b_mag_reg <= magnitude(req_b, req_signed);
         neg_reg   <= req_signed && (req_a[OP_W-1] ^ req_b[OP_W-1]);
      end
   end

   // Digit-pair walk and accumulation; cleared on every accept
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg <= '0;
         i_reg   <= '0;
         j_reg   <= '0;
      end else if (accept) begin
         acc_reg <= '0;
         i_reg   <= '0;
         j_reg   <= '0;
      end else if (state_reg == S_MUL) begin
         acc_reg <= acc_reg + pp_shifted;
         if (j_reg == LAST_DIG) begin
            j_reg <= '0;
            i_reg <= last_pp ? '0 : (i_reg + CNT_ONE);
         end else begin
            j_reg <= j_reg + CNT_ONE;
         end
      end
   end

   // Result register: signed fix-up applied once, then held until the next FIX
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_p_reg    <= '0;
         rsp_sign_reg <= 1'b0;
      end else if (state_reg == S_FIX) begin
         rsp_p_reg    <= neg_reg ? -acc_reg : acc_reg;
         // A zero product is never reported negative, whatever the operand signs
         rsp_sign_reg <= neg_reg && (acc_reg != '0);
      end
   end

   assign rsp_p    = rsp_p_reg;
   assign rsp_sign = rsp_sign_reg;

endmodule

// File: tb/tb_mulu_seq_ctrl.sv
// Self-checking bench for mulu_seq_ctrl: directed corner cases plus random
// operands, compared against a plain-arithmetic reference product.
`timescale 1ns/1ps
module tb_mulu_seq_ctrl;

   localparam int DW     = 2;
   localparam int ND     = 4;
   localparam int OP_W   = DW * ND;
   localparam int PROD_W = 2 * OP_W;
   localparam int LAT    = ND * ND + 1;

   logic              clk        = 1'b0;
   logic              reset      = 1'b1;
   logic              req_valid  = 1'b0;
   logic              req_ready;
   logic [OP_W-1:0]   req_a      = '0;
   logic [OP_W-1:0]   req_b      = '0;
   logic              req_signed = 1'b0;
   logic              rsp_valid;
   logic              rsp_ready  = 1'b0;
   logic [PROD_W-1:0] rsp_p;
   logic              rsp_sign;

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Count rising edges; read on falling edges, where it equals the last edge number
   always @(posedge clk) cyc <= cyc + 1;

   mulu_seq_ctrl #(
      .DIG_WIDTH (DW),
      .NDIG      (ND)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_p      (rsp_p),
      .rsp_sign   (rsp_sign)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: integer product of the operands as numbers, then truncated to PROD_W
   function automatic logic [PROD_W:0] ref_mul(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b,
                                               input logic            s);
      longint av, bv, pv;
      logic [63:0] pbits;
      av    = s ? longint'($signed(a)) : longint'(a);
      bv    = s ? longint'($signed(b)) : longint'(b);
      pv    = av * bv;
      pbits = pv;
      return {(s && (pv < 0)), pbits[PROD_W-1:0]};
   endfunction

   // Wait (bounded) on falling edges until rsp_valid is seen
   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One full transaction; stall = cycles rsp_ready stays low after rsp_valid,
   // early = rsp_ready raised during MUL (ignored until rsp_valid is up)
   task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                         input logic s, input int stall, input logic early,
                         input string tag);
      logic [PROD_W:0] exp;
      int n, t0;
      exp = ref_mul(a, b, s);
      @(negedge clk);
      req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_accept"}, req_ready, 1);
      @(negedge clk);
      t0 = cyc;
      req_valid = 1'b0;
      if (early) begin
         rsp_ready = 1'b1;
         @(negedge clk);
         check_val({tag, "_early_v"}, rsp_valid, 0);
      end
      wait_rsp();
      check_val({tag, "_lat"}, cyc - t0, LAT);
      check_val({tag, "_p"}, rsp_p, exp[PROD_W-1:0]);
      check_val({tag, "_sign"}, rsp_sign, exp[PROD_W]);
      for (int k = 0; k < stall; k++) begin
         req_valid = (k == 1);
         req_a = 8'h5A; req_b = 8'hA5;
         @(negedge clk);
         check_val({tag, "_hold_p"}, rsp_p, exp[PROD_W-1:0]);
         check_val({tag, "_hold_v"}, rsp_valid, 1);
         check_val({tag, "_hold_rdy"}, req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      if (!early) @(negedge clk);
      else        @(negedge clk);
      rsp_ready = 1'b0;
      check_val({tag, "_post_v"}, rsp_valid, 0);
      check_val({tag, "_post_rdy"}, req_ready, 1);
      check_val({tag, "_post_p"}, rsp_p, exp[PROD_W-1:0]);
      $display("op %s: a=0x%02h b=0x%02h signed=%0d -> p=0x%04h sign=%0d (ref 0x%04h/%0d)",
               tag, a, b, s, rsp_p, rsp_sign, exp[PROD_W-1:0], exp[PROD_W]);
   endtask

   initial begin
      logic [PROD_W:0] e1, e2;
      int t0, h;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_ready_during", req_ready, 0);
      reset = 1'b0;
      #1;
      check_val("rst_ready", req_ready, 1);
      check_val("rst_valid", rsp_valid, 0);
      check_val("rst_p", rsp_p, 0);
      check_val("rst_sign", rsp_sign, 0);

      // Directed corners
      run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, "u_ff_ff");
      run_op(8'h80, 8'h80, 1'b1, 0, 1'b0, "s_m128_sq");
      run_op(8'h00, 8'hFB, 1'b1, 1, 1'b0, "s_zero_neg");
      run_op(8'h80, 8'h02, 1'b0, 0, 1'b1, "u_80_02");
      run_op(8'h12, 8'h34, 1'b0, 5, 1'b0, "u_stall5");
      run_op(8'hFD, 8'h05, 1'b1, 0, 1'b0, "s_m3_5");

      // Reset mid-MUL: previous result (0xFFF1, sign 1) must be discarded
      @(negedge clk);
      req_a = 8'h77; req_b = 8'h66; req_signed = 1'b0; req_valid = 1'b1;
      wait_rdy: for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
      @(negedge clk);
      t0 = cyc;
      req_valid = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("midrst_valid", rsp_valid, 0);
      check_val("midrst_ready", req_ready, 1);
      check_val("midrst_p", rsp_p, 0);
      check_val("midrst_sign", rsp_sign, 0);
      $display("op midrst: reset at edge %0d (accept edge %0d)", t0 + 8, t0);
      run_op(8'h07, 8'h09, 1'b0, 0, 1'b0, "u_7_9");

      // Back-to-back with req_valid held high across the handshake
      e1 = ref_mul(8'h21, 8'h43, 1'b0);
      e2 = ref_mul(8'hC7, 8'h19, 1'b1);
      @(negedge clk);
      req_a = 8'h21; req_b = 8'h43; req_signed = 1'b0; req_valid = 1'b1;
      for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
      @(negedge clk);
      t0 = cyc;
      req_a = 8'hC7; req_b = 8'h19; req_signed = 1'b1;
      wait_rsp();
      check_val("b2b1_lat", cyc - t0, LAT);
      check_val("b2b1_p", rsp_p, e1[PROD_W-1:0]);
      check_val("b2b1_sign", rsp_sign, e1[PROD_W]);
      rsp_ready = 1'b1;
      @(negedge clk);
      h = cyc;
      rsp_ready = 1'b0;
      check_val("b2b_idle_ready", req_ready, 1);
      check_val("b2b_idle_valid", rsp_valid, 0);
      @(negedge clk);
      check_val("b2b_taken", req_ready, 0);
      req_valid = 1'b0;
      wait_rsp();
      check_val("b2b2_lat", cyc - h, LAT + 1);
      check_val("b2b2_p", rsp_p, e2[PROD_W-1:0]);
      check_val("b2b2_sign", rsp_sign, e2[PROD_W]);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_val("b2b2_post_v", rsp_valid, 0);
      $display("op b2b: 0x21*0x43 -> 0x%04h, 0xC7*0x19 signed -> 0x%04h", e1[PROD_W-1:0], e2[PROD_W-1:0]);

      // Random operands
      for (int r = 0; r < 24; r++) begin
         logic [OP_W-1:0] ra, rb;
         logic rs;
         ra = OP_W'($urandom);
         rb = OP_W'($urandom);
         rs = 1'($urandom);
         if (r % 5 == 4) run_op(ra, rb, rs, 0, 1'b1, "rnd_early");
         else            run_op(ra, rb, rs, int'($urandom_range(0, 3)), 1'b0, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute bound on run time
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
